id_instr_buffer: RTL and testbench
==================================

# id_instr_buffer

Parametrised instruction buffer between fetch and decode. It stores {pc, instr} pairs in a circular queue and pre-classifies each MIPS32 word at enqueue. It tags delay-slot instructions and presents the head entry, optionally paired with its delay slot, to the decode stage under a valid/ready handshake. It decouples fetch from decode stalls and lets decode see a branch and its delay slot together.

## Interface
- DEPTH, 8: entries; power of two, ≥4.
- CNT_W, $clog2(DEPTH)+1: width of occupancy count.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low; one clock; sampled on rising clk.
- flush_i  in  1  discard all entries (exception/ERET redirect).
- enq_valid_i  in  1  fetch offers an entry.
- enq_ready_o  out  1  buffer accepts an entry this cycle.
- enq_pc_i  in  32  PC of offered instruction.
- enq_instr_i  in  32  instruction word.
- deq_valid_o  out  1  head entry (or pair) is issuable.
- deq_ready_i  in  1  decode consumes.
- deq_pc_o, deq_instr_o  out  32 each  head PC/word.
- deq_ctrl_o  out  1  head is branch/jump.
- deq_mem_o  out  1  head is load/store (LB..SC, LWL/LWR/SWL/SWR).
- deq_priv_o  out  1  head is COP0 op (op 0x10), SYSCALL, BREAK or ERET.
- deq_in_ds_o  out  1  head occupies a delay slot.
- deq_pair_o  out  1  head and next entry issue together.
- deq_ds_pc_o, deq_ds_instr_o  out  32 each  second entry (valid only when deq_pair_o).
- count_o  out  CNT_W  current occupancy.

## Operation
- Storage: DEPTH-entry circular array, rd/wr pointers of CNT_W-1 bits wrapping modulo DEPTH, plus count register.
- Classification at enqueue, stored per entry:
  - ctrl = op∈{J,JAL,BEQ,BNE,BLEZ,BGTZ and the BxxL variants}, or op=REGIMM with rt∈{0x00–0x03,0x10–0x13}, or op=0 with func∈{0x08,0x09}.
  - mem and priv as defined on the ports.
- Delay-slot tag: register last_ctrl holds ctrl of the most recently accepted entry. An accepted entry gets in_ds=last_ctrl. last_ctrl clears on reset and flush.
- Enqueue: accepted when enq_valid_i & enq_ready_o. enq_ready_o = (count<DEPTH) & ~flush_i.
- Dequeue:
  - deq_valid_o = (count≥1) & ~flush_i, except as modified by pairing.
  - Single pop when deq_valid_o & deq_ready_i & ~deq_pair_o. Double pop when deq_pair_o & deq_ready_i.
- Simultaneous enq+deq: count changes by accepted−popped. Enqueue when count=DEPTH is refused even if a pop occurs in the same cycle.
- Flush: count, pointers and last_ctrl clear next edge. Enqueue and dequeue are both suppressed in the flush cycle. Flush wins over resetn=1 traffic. Reset wins over flush.
- Head outputs come from registered storage. No enq→deq bypass.

## Timing
- Reset values: count_o=0, deq_valid_o=0, enq_ready_o=1 (when flush_i=0), deq_pair_o=0. Data/class outputs are 0 while empty (mask on count=0).
- Latency: entry accepted at edge n is visible on deq_* after edge n (cycle n+1).
- Pop at edge n: the next entry is presented in cycle n+1.
- Full→one pop: enq_ready_o rises the cycle after the pop.
- Pointer wrap: entry DEPTH-1 is followed by entry 0 with no bubble.

## Configuration
- ID_BRANCH_PAIR_EN defined:
  - When the head has ctrl=1, deq_valid_o asserts only if count≥2. deq_pair_o then equals 1, and deq_ds_* present entry rd+1, wrapping.
  - A handshake pops both entries.
  - A ctrl head with count=1 holds, deq_valid_o=0, until its delay slot arrives or a flush occurs.
- ID_BRANCH_PAIR_EN undefined:
  - deq_pair_o=0 and deq_ds_*=0 always.
  - Every entry issues singly, and ctrl heads issue with count≥1.

## Test plan
- Reset, then enqueue pc=0xBFC00000, instr=0x24010001 (ADDIU) → next cycle deq_valid_o=1, deq_ctrl_o=0, deq_in_ds_o=0, count_o=1. Pop → count_o=0.
- Fill DEPTH=8 with deq_ready_i=0 → count_o=8 and enq_ready_o=0. Then pop one with enq_valid_i held → 9th entry is accepted only the cycle after the pop. Entries emerge in order across the pointer wrap.
- With the macro, enqueue BEQ (0x10220003) at 0x100, stall fetch → deq_valid_o=0 while count_o=1. Enqueue NOP at 0x104 → deq_pair_o=1, deq_ds_pc_o=0x104. One handshake → count_o=0.
- Without the macro, the same stimulus → BEQ issues alone with deq_ctrl_o=1. The NOP then issues with deq_in_ds_o=1.
- Enqueue 5 entries, including JR (0x03E00008) as the last, then assert flush_i with enq_valid_i=1 → count_o=0 next cycle, and the offered entry is dropped. The next enqueued entry has deq_in_ds_o=0.
- Enqueue SYSCALL (0x0000000C), LW (0x8C220000), MTC0 (0x40826000) → deq_priv_o/deq_mem_o/deq_priv_o respectively. Assert resetn=0 mid-stream → all outputs return to reset values after one edge.

Source files
------------

// File: rtl/id_instr_buffer.sv
// id_instr_buffer: circular instruction queue between fetch and decode.
// Each {pc, instr} pair is pre-classified at enqueue as control, memory or
// privileged, and is tagged when it sits in a branch delay slot.
// Optional feature macro: ID_BRANCH_PAIR_EN. When it is defined, a control head
// waits for its delay slot and the two entries issue together as a pair.
module id_instr_buffer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush_i,
   input  logic             enq_valid_i,
   output logic             enq_ready_o,
   input  logic [31:0]      enq_pc_i,
   input  logic [31:0]      enq_instr_i,
   output logic             deq_valid_o,
   input  logic             deq_ready_i,
   output logic [31:0]      deq_pc_o,
   output logic [31:0]      deq_instr_o,
   output logic             deq_ctrl_o,
   output logic             deq_mem_o,
   output logic             deq_priv_o,
   output logic             deq_in_ds_o,
   output logic             deq_pair_o,
   output logic [31:0]      deq_ds_pc_o,
   output logic [31:0]      deq_ds_instr_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned     PTR_W    = CNT_W - 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] TWO_CNT  = CNT_W'(2);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        ctrl;
      logic        mem;
      logic        priv;
      logic        in_ds;
   } entry_t;

   entry_t           ent_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             last_ctrl_q;

   logic [5:0]       op;
   logic [4:0]       rt;
   logic [5:0]       func;
   logic             cls_ctrl;
   logic             cls_mem;
   logic             cls_priv;

   entry_t           head;
   logic             has_one;
   logic             has_two;
   logic             valid_c;
   logic             pair_c;
   logic             accept;
   logic [1:0]       pop_n;
   logic [CNT_W-1:0] count_d;

`ifdef ID_BRANCH_PAIR_EN
   logic [PTR_W-1:0] rd_nxt;
`endif

   // Decode the offered MIPS32 word into control / memory / privileged classes
   always_comb begin
      op       = enq_instr_i[31:26];
      rt       = enq_instr_i[20:16];
      func     = enq_instr_i[5:0];
      cls_ctrl = 1'b0;
      cls_mem  = 1'b0;
      cls_priv = 1'b0;
      case (op)
         6'h00: begin
            cls_ctrl = (func == 6'h08) || (func == 6'h09);
            cls_priv = (func == 6'h0C) || (func == 6'h0D);
         end
         6'h01: cls_ctrl = (rt[4:2] == 3'b000) || (rt[4:2] == 3'b100);
         6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
         6'h14, 6'h15, 6'h16, 6'h17: cls_ctrl = 1'b1;
         6'h10: cls_priv = 1'b1;
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
         6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E, 6'h30, 6'h38: cls_mem = 1'b1;
         default: begin
            cls_ctrl = 1'b0;
            cls_mem  = 1'b0;
            cls_priv = 1'b0;
         end
      endcase
   end

   // Handshake decisions: issue validity, pairing, accept and pop counts
   always_comb begin
      head    = ent_q[rd_ptr_q];
      has_one = (count_q != '0);
      has_two = (count_q >= TWO_CNT);
`ifdef ID_BRANCH_PAIR_EN
      rd_nxt  = rd_ptr_q + PTR_W'(1);
      // A branch head holds until its delay slot is present behind it
      pair_c  = ~flush_i & head.ctrl & has_two;
      valid_c = ~flush_i & has_one & (~head.ctrl | has_two);
`else
      pair_c  = 1'b0;
      valid_c = ~flush_i & has_one;
`endif
      // Full refuses entry even if a pop frees a slot this same cycle
      enq_ready_o = (count_q != FULL_CNT) & ~flush_i;
      accept      = enq_valid_i & enq_ready_o;
      pop_n       = 2'd0;
      if (valid_c && deq_ready_i) begin
         pop_n = pair_c ? 2'd2 : 2'd1;
      end
      count_d = count_q + CNT_W'(accept) - CNT_W'(pop_n);
   end

   // Head presentation, masked to zero while the queue is empty
   always_comb begin
      deq_valid_o    = valid_c;
      deq_pair_o     = pair_c;
      deq_pc_o       = has_one ? head.pc    : 32'h0;
      deq_instr_o    = has_one ? head.instr : 32'h0;
      deq_ctrl_o     = has_one & head.ctrl;
      deq_mem_o      = has_one & head.mem;
      deq_priv_o     = has_one & head.priv;
      deq_in_ds_o    = has_one & head.in_ds;
      deq_ds_pc_o    = 32'h0;
      deq_ds_instr_o = 32'h0;
`ifdef ID_BRANCH_PAIR_EN
      if (pair_c) begin
         deq_ds_pc_o    = ent_q[rd_nxt].pc;
         deq_ds_instr_o = ent_q[rd_nxt].instr;
      end
`endif
      count_o = count_q;
   end

   // Pointers, occupancy and delay-slot tracking; reset beats flush beats traffic
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         last_ctrl_q <= 1'b0;
      end else if (flush_i) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         last_ctrl_q <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_q + PTR_W'(pop_n);
         count_q  <= count_d;
         if (accept) begin
            wr_ptr_q    <= wr_ptr_q + PTR_W'(1);
            last_ctrl_q <= cls_ctrl;
         end
      end
   end

   // Entry storage; contents need no reset since occupancy gates visibility
   always_ff @(posedge clk) begin
      if (resetn && accept) begin
         ent_q[wr_ptr_q] <= '{pc:    enq_pc_i,
                               instr: enq_instr_i,
                               ctrl:  cls_ctrl,
                               mem:   cls_mem,
                               priv:  cls_priv,
                               in_ds: last_ctrl_q};
      end
   end

endmodule

// File: tb/tb_id_instr_buffer.sv
// Self-checking bench for id_instr_buffer (honours ID_BRANCH_PAIR_EN).
module tb_id_instr_buffer;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             clk;
   logic             resetn;
   logic             flush_i;
   logic             enq_valid_i;
   logic             enq_ready_o;
   logic [31:0]      enq_pc_i;
   logic [31:0]      enq_instr_i;
   logic             deq_valid_o;
   logic             deq_ready_i;
   logic [31:0]      deq_pc_o;
   logic [31:0]      deq_instr_o;
   logic             deq_ctrl_o;
   logic             deq_mem_o;
   logic             deq_priv_o;
   logic             deq_in_ds_o;
   logic             deq_pair_o;
   logic [31:0]      deq_ds_pc_o;
   logic [31:0]      deq_ds_instr_o;
   logic [CNT_W-1:0] count_o;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        ctrl;
      logic        mem;
      logic        priv;
      logic        in_ds;
   } sb_t;

   sb_t  sb [$];
   logic last_ctrl;
   int   total;
   int   bad;

   id_instr_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .flush_i       (flush_i),
      .enq_valid_i   (enq_valid_i),
      .enq_ready_o   (enq_ready_o),
      .enq_pc_i      (enq_pc_i),
      .enq_instr_i   (enq_instr_i),
      .deq_valid_o   (deq_valid_o),
      .deq_ready_i   (deq_ready_i),
      .deq_pc_o      (deq_pc_o),
      .deq_instr_o   (deq_instr_o),
      .deq_ctrl_o    (deq_ctrl_o),
      .deq_mem_o     (deq_mem_o),
      .deq_priv_o    (deq_priv_o),
      .deq_in_ds_o   (deq_in_ds_o),
      .deq_pair_o    (deq_pair_o),
      .deq_ds_pc_o   (deq_ds_pc_o),
      .deq_ds_instr_o(deq_ds_instr_o),
      .count_o       (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, compare against the scoreboard model, then advance the model
   task automatic step(input logic fl, input logic ev, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ec, input logic em,
                       input logic ep, input logic rdy);
      sb_t  h;
      sb_t  s;
      int   n;
      logic exp_rdy;
      logic exp_val;
      logic exp_pair;
      flush_i     = fl;
      enq_valid_i = ev;
      enq_pc_i    = pc;
      enq_instr_i = ins;
      deq_ready_i = rdy;
      #1;
      n        = sb.size();
      exp_rdy  = (n < int'(DEPTH)) && !fl;
      exp_val  = 1'b0;
      exp_pair = 1'b0;
      if (n > 0) h = sb[0];
      if (n > 0 && !fl) begin
`ifdef ID_BRANCH_PAIR_EN
         exp_pair = h.ctrl && (n >= 2);
         exp_val  = !h.ctrl || (n >= 2);
`else
         exp_val  = 1'b1;
`endif
      end
      chk("enq_ready", 32'(enq_ready_o), 32'(exp_rdy));
      chk("deq_valid", 32'(deq_valid_o), 32'(exp_val));
      chk("deq_pair",  32'(deq_pair_o),  32'(exp_pair));
      chk("count",     32'(count_o),     32'(n));
      if (n > 0) begin
         chk("head_pc",    deq_pc_o,            h.pc);
         chk("head_instr", deq_instr_o,         h.instr);
         chk("head_ctrl",  32'(deq_ctrl_o),     32'(h.ctrl));
         chk("head_mem",   32'(deq_mem_o),      32'(h.mem));
         chk("head_priv",  32'(deq_priv_o),     32'(h.priv));
         chk("head_in_ds", 32'(deq_in_ds_o),    32'(h.in_ds));
      end else begin
         chk("empty_pc",   deq_pc_o,            32'h0);
         chk("empty_cls",  32'({deq_ctrl_o, deq_mem_o, deq_priv_o, deq_in_ds_o}), 32'h0);
      end
      if (exp_pair) begin
         chk("ds_pc",    deq_ds_pc_o,    sb[1].pc);
         chk("ds_instr", deq_ds_instr_o, sb[1].instr);
      end else begin
         chk("ds_pc_zero", deq_ds_pc_o, 32'h0);
      end
      if (fl) begin
         sb.delete();
         last_ctrl = 1'b0;
      end else begin
         if (exp_val && rdy) begin
            void'(sb.pop_front());
            if (exp_pair) void'(sb.pop_front());
         end
         if (ev && exp_rdy) begin
            s.pc = pc; s.instr = ins; s.ctrl = ec; s.mem = em; s.priv = ep;
            s.in_ds = last_ctrl;
            sb.push_back(s);
            last_ctrl = ec;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, rdy);
   endtask

   task automatic enq(input logic [31:0] pc, input logic [31:0] ins,
                      input logic ec, input logic em, input logic ep);
      step(1'b0, 1'b1, pc, ins, ec, em, ep, 1'b0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_count"},     32'(count_o),     32'h0);
      chk({tag, "_deq_valid"}, 32'(deq_valid_o), 32'h0);
      chk({tag, "_enq_ready"}, 32'(enq_ready_o), 32'h1);
      chk({tag, "_deq_pair"},  32'(deq_pair_o),  32'h0);
      chk({tag, "_deq_pc"},    deq_pc_o,         32'h0);
      chk({tag, "_deq_instr"}, deq_instr_o,      32'h0);
      chk({tag, "_cls"}, 32'({deq_ctrl_o, deq_mem_o, deq_priv_o, deq_in_ds_o}), 32'h0);
   endtask

   initial begin
      total = 0; bad = 0; last_ctrl = 1'b0;
      resetn = 1'b0; flush_i = 1'b0; enq_valid_i = 1'b0;
      enq_pc_i = 32'h0; enq_instr_i = 32'h0; deq_ready_i = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check_reset_state("rst");
      resetn = 1'b1;
      #1;

      // First entry and its one-cycle latency, then a pop
      enq(32'hBFC0_0000, 32'h2401_0001, 1'b0, 1'b0, 1'b0);
      chk("first_valid", 32'(deq_valid_o), 32'h1);
      chk("first_count", 32'(count_o), 32'h1);
      idle(1'b1);
      chk("first_drained", 32'(count_o), 32'h0);

      // Fill to DEPTH, then full-with-pop refuses the 9th; it enters one cycle later
      for (int i = 0; i < 8; i++)
         enq(32'h0000_1000 + 32'(i * 4), 32'h2401_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
      chk("full_count", 32'(count_o), 32'h8);
      chk("full_ready", 32'(enq_ready_o), 32'h0);
      step(1'b0, 1'b1, 32'h0000_1020, 32'h2401_0008, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'h0000_1020, 32'h2401_0008, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("refill_count", 32'(count_o), 32'h8);
      for (int i = 0; i < 9; i++) idle(1'b1);
      chk("wrap_drained", 32'(count_o), 32'h0);

      // Branch with delay slot: held then paired, or issued singly
      enq(32'h0000_0100, 32'h1022_0003, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
`ifdef ID_BRANCH_PAIR_EN
      chk("beq_held", 32'(deq_valid_o), 32'h0);
`else
      chk("beq_alone", 32'(deq_ctrl_o), 32'h1);
`endif
      enq(32'h0000_0104, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
`ifdef ID_BRANCH_PAIR_EN
      chk("pair_ds_pc", deq_ds_pc_o, 32'h0000_0104);
`endif
      idle(1'b1);
      idle(1'b1);
      chk("branch_drained", 32'(count_o), 32'h0);

      // Flush with JR at the tail drops the offered entry and clears the DS tag
      for (int i = 0; i < 4; i++)
         enq(32'h0000_0200 + 32'(i * 4), 32'h2401_0010 + 32'(i), 1'b0, 1'b0, 1'b0);
      enq(32'h0000_0210, 32'h03E0_0008, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h0000_0214, 32'h2401_0020, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("flush_count", 32'(count_o), 32'h0);
      enq(32'h0000_2000, 32'h2401_0030, 1'b0, 1'b0, 1'b0);
      chk("post_flush_ds", 32'(deq_in_ds_o), 32'h0);
      idle(1'b1);

      // Class flags, then reset mid-stream
      enq(32'h0000_3000, 32'h0000_000C, 1'b0, 1'b0, 1'b1);
      enq(32'h0000_3004, 32'h8C22_0000, 1'b0, 1'b1, 1'b0);
      enq(32'h0000_3008, 32'h4082_6000, 1'b0, 1'b0, 1'b1);
      chk("syscall_priv", 32'(deq_priv_o), 32'h1);
      idle(1'b1);
      chk("lw_mem", 32'(deq_mem_o), 32'h1);
      idle(1'b1);
      chk("mtc0_priv", 32'(deq_priv_o), 32'h1);
      step(1'b0, 1'b1, 32'h0000_300C, 32'h2401_0040, 1'b0, 1'b0, 1'b0, 1'b0);
      resetn = 1'b0; flush_i = 1'b1; enq_valid_i = 1'b1; deq_ready_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0; enq_valid_i = 1'b0; deq_ready_i = 1'b0;
      #1;
      check_reset_state("midrst");
      sb.delete();
      last_ctrl = 1'b0;
      resetn = 1'b1;
      #1;
      idle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
